// File: rtl/gp_engine_pkg.sv
// rtl/gp_engine_pkg.sv - shared command types, entry field positions and executor states
package gp_engine_pkg;

  // Command type codes carried in the low bits of every buffer entry
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_RWM   = 2'b01;

  // Entry field positions: {addr[31:2], data[31:0], type[1:0]}
  localparam int CMD_TYPE_LSB = 0;
  localparam int CMD_TYPE_MSB = 1;
  localparam int CMD_DATA_LSB = 2;
  localparam int CMD_DATA_MSB = 33;
  localparam int CMD_ADDR_LSB = 34;
  localparam int CMD_ADDR_MSB = 63;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_CMD,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FETCH2,
    ST_WAIT_CMD2,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/cmd_executor_if.sv
// rtl/cmd_executor_if.sv - bus master request/response signal bundle
interface cmd_executor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mst_o_valid;
  logic [ADDR_WIDTH-1:0] mst_o_addr;
  logic [DATA_WIDTH-1:0] mst_o_wr_data;
  logic                  mst_o_rd0_wr1;
  logic                  mst_i_ready;
  logic [DATA_WIDTH-1:0] mst_i_rd_data;
  logic                  mst_i_rd_valid;

  modport master (
    output mst_o_valid,
    output mst_o_addr,
    output mst_o_wr_data,
    output mst_o_rd0_wr1,
    input  mst_i_ready,
    input  mst_i_rd_data,
    input  mst_i_rd_valid
  );

  modport slave (
    input  mst_o_valid,
    input  mst_o_addr,
    input  mst_o_wr_data,
    input  mst_o_rd0_wr1,
    output mst_i_ready,
    output mst_i_rd_data,
    output mst_i_rd_valid
  );
endinterface

// File: rtl/gp_watchdog.sv
// rtl/gp_watchdog.sv - per-state cycle counter that flags expiry after LIMIT cycles
module gp_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int CW = ($clog2(LIMIT) > 0) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  // expire fires on the LIMIT-th consecutive cycle spent in a counted state
  assign expire = count && (cnt == CW'(LIMIT - 1));

  // load restarts the count for the state being entered next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cmd_executor.sv
// rtl/cmd_executor.sv - command buffer walker issuing WRITE / read-modify-write bus ops; TIMEOUT_EN adds a wait watchdog
module cmd_executor
  import gp_engine_pkg::*;
#(
  parameter int CMD_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR = 32'h0000_04A0
`ifdef TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  mst_o_valid,
  output logic [ADDR_WIDTH-1:0] mst_o_addr,
  output logic [DATA_WIDTH-1:0] mst_o_wr_data,
  output logic                  mst_o_rd0_wr1,
  input  logic                  mst_i_ready,
  input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
  input  logic                  mst_i_rd_valid
);

  state_t state, state_next;

  logic [1:0]            cmd_type;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [ADDR_WIDTH-1:0] cmd_baddr;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  at_end;

  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] m_q;
  logic [DATA_WIDTH-1:0] r_q;

  logic mst_valid, mst_wr;
  logic clr_addr, inc_addr, ld_wr, ld_rwm, ld_r, ld_merge;
  logic wd_expire;

  assign cmd_type  = cmd_out[CMD_TYPE_MSB:CMD_TYPE_LSB];
  assign cmd_data  = cmd_out[CMD_DATA_MSB:CMD_DATA_LSB];
  assign cmd_baddr = {cmd_out[CMD_ADDR_MSB:CMD_ADDR_LSB], 2'b00};
  assign addr_inc  = cmd_addr_q + ADDR_WIDTH'(4);
  assign at_end    = (addr_inc == END_ADDR);

  assign cmd_addr      = cmd_addr_q;
  assign mst_o_valid   = mst_valid;
  assign mst_o_rd0_wr1 = mst_wr;
  assign mst_o_addr    = addr_q;
  assign mst_o_wr_data = wdata_q;

`ifdef TIMEOUT_EN
  logic wd_count, wd_load;

  assign wd_count = (state == ST_WAIT_CMD) || (state == ST_WAIT_CMD2) ||
                    (state == ST_WR_REQ) || (state == ST_RD_REQ) ||
                    (state == ST_RD_WAIT);
  assign wd_load  = (state_next != state);

  gp_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .count  (wd_count),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, Moore outputs and datapath load strobes
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cmd_rd_en  = 1'b0;
    mst_valid  = 1'b0;
    mst_wr     = 1'b0;
    clr_addr   = 1'b0;
    inc_addr   = 1'b0;
    ld_wr      = 1'b0;
    ld_rwm     = 1'b0;
    ld_r       = 1'b0;
    ld_merge   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          clr_addr   = 1'b1;
        end
      end
      ST_FETCH: begin
        busy       = 1'b1;
        cmd_rd_en  = 1'b1;
        state_next = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        busy = 1'b1;
        if (cmd_rd_valid) begin
          // an all-zero entry terminates the list even though its type decodes as WRITE
          if (cmd_out == '0) begin
            state_next = ST_DONE;
          end else if (cmd_type == CMD_WRITE) begin
            state_next = ST_WR_REQ;
            ld_wr      = 1'b1;
          end else if (cmd_type == CMD_RWM) begin
            state_next = ST_RD_REQ;
            ld_rwm     = 1'b1;
          end else begin
            state_next = ST_ERR;
          end
        end else if (wd_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_WR_REQ: begin
        busy      = 1'b1;
        mst_valid = 1'b1;
        mst_wr    = 1'b1;
        if (mst_i_ready) begin
          inc_addr   = 1'b1;
          state_next = at_end ? ST_DONE : ST_FETCH;
        end else if (wd_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_RD_REQ: begin
        busy      = 1'b1;
        mst_valid = 1'b1;
        if (mst_i_ready) begin
          state_next = ST_RD_WAIT;
        end else if (wd_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_RD_WAIT: begin
        busy = 1'b1;
        if (mst_i_rd_valid) begin
          ld_r       = 1'b1;
          inc_addr   = 1'b1;
          // the write half of an RWM pair cannot live past the end of the buffer
          state_next = at_end ? ST_ERR : ST_FETCH2;
        end else if (wd_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_FETCH2: begin
        busy       = 1'b1;
        cmd_rd_en  = 1'b1;
        state_next = ST_WAIT_CMD2;
      end
      ST_WAIT_CMD2: begin
        busy = 1'b1;
        if (cmd_rd_valid) begin
          if (cmd_type == CMD_WRITE) begin
            state_next = ST_WR_REQ;
            ld_merge   = 1'b1;
          end else begin
            state_next = ST_ERR;
          end
        end else if (wd_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        error      = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Entry pointer, bus request registers and the RWM address/mask/read latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
    end else begin
      if (clr_addr) begin
        cmd_addr_q <= '0;
      end else if (inc_addr) begin
        cmd_addr_q <= addr_inc;
      end
      if (ld_wr) begin
        addr_q  <= cmd_baddr;
        wdata_q <= cmd_data;
      end
      if (ld_rwm) begin
        a_q    <= cmd_baddr;
        m_q    <= cmd_data;
        addr_q <= cmd_baddr;
      end
      if (ld_r) begin
        r_q <= mst_i_rd_data;
      end
      if (ld_merge) begin
        addr_q  <= a_q;
        wdata_q <= (r_q & m_q) | cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_cmd_executor.sv
// tb/tb_cmd_executor.sv - directed table-driven bench for cmd_executor
module tb_cmd_executor;
  import gp_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error, cmd_rd_en;
  logic [31:0] cmd_addr;
  logic        cmd_rd_valid;
  logic [63:0] cmd_out;

  always #5 clk = ~clk;

  cmd_executor_if bus ();

`ifdef TIMEOUT_EN
  cmd_executor #(
    .TIMEOUT_CYCLES (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .cmd_rd_en      (cmd_rd_en),
    .cmd_addr       (cmd_addr),
    .cmd_rd_valid   (cmd_rd_valid),
    .cmd_out        (cmd_out),
    .mst_o_valid    (bus.mst_o_valid),
    .mst_o_addr     (bus.mst_o_addr),
    .mst_o_wr_data  (bus.mst_o_wr_data),
    .mst_o_rd0_wr1  (bus.mst_o_rd0_wr1),
    .mst_i_ready    (bus.mst_i_ready),
    .mst_i_rd_data  (bus.mst_i_rd_data),
    .mst_i_rd_valid (bus.mst_i_rd_valid)
  );
`else
  cmd_executor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .cmd_rd_en      (cmd_rd_en),
    .cmd_addr       (cmd_addr),
    .cmd_rd_valid   (cmd_rd_valid),
    .cmd_out        (cmd_out),
    .mst_o_valid    (bus.mst_o_valid),
    .mst_o_addr     (bus.mst_o_addr),
    .mst_o_wr_data  (bus.mst_o_wr_data),
    .mst_o_rd0_wr1  (bus.mst_o_rd0_wr1),
    .mst_i_ready    (bus.mst_i_ready),
    .mst_i_rd_data  (bus.mst_i_rd_data),
    .mst_i_rd_valid (bus.mst_i_rd_valid)
  );
`endif

  // Command buffer model: one-cycle registered read
  logic [63:0] mem [0:511];
  always @(posedge clk) begin
    if (!rst_n) begin
      cmd_rd_valid <= 1'b0;
      cmd_out      <= 64'h0;
    end else begin
      cmd_rd_valid <= cmd_rd_en;
      cmd_out      <= cmd_rd_en ? mem[cmd_addr[10:2]] : 64'h0;
    end
  end

  // Bus slave model: read data returned the cycle after acceptance unless held
  logic        rd_hold;
  logic [31:0] rd_value;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.mst_i_rd_valid <= 1'b0;
      bus.mst_i_rd_data  <= 32'h0;
    end else if (bus.mst_o_valid && bus.mst_i_ready && !bus.mst_o_rd0_wr1 && !rd_hold) begin
      bus.mst_i_rd_valid <= 1'b1;
      bus.mst_i_rd_data  <= rd_value;
    end else begin
      bus.mst_i_rd_valid <= 1'b0;
    end
  end

  // Monitor: pulse counters, transaction logs and protocol watch
  int          n_done = 0, n_err = 0, n_req = 0, n_reads = 0;
  int          fetch_viol = 0, proto_viol = 0;
  logic [31:0] fetch_q [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] rd_addr_q [$];
  logic        rd_en_prev = 1'b0, rst_prev = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = 32'h0, p_data = 32'h0;

  always @(posedge clk) begin
    if (done) n_done <= n_done + 1;
    if (error) n_err <= n_err + 1;
    if (bus.mst_o_valid) n_req <= n_req + 1;
    if (cmd_rd_en) fetch_q.push_back(cmd_addr);
    if (cmd_rd_en && rd_en_prev) fetch_viol <= fetch_viol + 1;
    if (bus.mst_o_valid && bus.mst_i_ready) begin
      if (bus.mst_o_rd0_wr1) begin
        wr_addr_q.push_back(bus.mst_o_addr);
        wr_data_q.push_back(bus.mst_o_wr_data);
      end else begin
        rd_addr_q.push_back(bus.mst_o_addr);
        n_reads <= n_reads + 1;
      end
    end
    if (rst_prev && p_valid && !p_ready && !error) begin
      if (!bus.mst_o_valid || bus.mst_o_addr != p_addr || bus.mst_o_wr_data != p_data ||
          bus.mst_o_rd0_wr1 != p_wr)
        proto_viol <= proto_viol + 1;
    end
    rd_en_prev <= cmd_rd_en;
    rst_prev   <= rst_n;
    p_valid    <= bus.mst_o_valid;
    p_ready    <= bus.mst_i_ready;
    p_wr       <= bus.mst_o_rd0_wr1;
    p_addr     <= bus.mst_o_addr;
    p_data     <= bus.mst_o_wr_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    logic [63:0] r;
    r = {30'(a >> 2), d, t};
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_rd_en"}, 32'(cmd_rd_en), 32'd0);
    check({tag, "_cmd_addr"}, cmd_addr, 32'd0);
    check({tag, "_valid"}, 32'(bus.mst_o_valid), 32'd0);
    check({tag, "_addr"}, bus.mst_o_addr, 32'd0);
    check({tag, "_wdata"}, bus.mst_o_wr_data, 32'd0);
    check({tag, "_wr"}, 32'(bus.mst_o_rd0_wr1), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget, input int d0, input int e0);
    int cyc = 0;
    while (n_done == d0 && n_err == e0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_end_timeout actual=%0d required<%0d", tag, cyc, budget);
    end
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 512; k++) mem[k] = 64'h0;
  endtask

  typedef struct {
    logic [3:0][63:0] ent;
    logic [31:0]      rd_value;
    int               exp_done;
    int               exp_err;
    int               exp_reads;
    int               exp_writes;
    int               exp_fetches;
    logic [31:0]      exp_raddr;
    logic [31:0]      exp_waddr;
    logic [31:0]      exp_wdata;
  } vec_t;

  vec_t tbl [6];

  task automatic run_case(input string tag, input vec_t v);
    int d0, e0, r0, w0, f0, q0;
    bit ok;
    clear_mem();
    for (int k = 0; k < 4; k++) mem[k] = v.ent[k];
    rd_value = v.rd_value;
    d0 = n_done; e0 = n_err; r0 = n_reads; w0 = wr_addr_q.size(); f0 = fetch_q.size(); q0 = n_req;
    pulse_start();
    wait_end(tag, 100, d0, e0);
    check({tag, "_done"}, n_done - d0, v.exp_done);
    check({tag, "_error"}, n_err - e0, v.exp_err);
    check({tag, "_reads"}, n_reads - r0, v.exp_reads);
    check({tag, "_writes"}, wr_addr_q.size() - w0, v.exp_writes);
    check({tag, "_fetches"}, fetch_q.size() - f0, v.exp_fetches);
    ok = 1'b1;
    for (int k = f0; k < fetch_q.size(); k++)
      if (fetch_q[k] !== 32'(4 * (k - f0))) ok = 1'b0;
    check({tag, "_fetch_seq"}, 32'(ok), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (v.exp_reads > 0 && rd_addr_q.size() > 0)
      check({tag, "_raddr"}, rd_addr_q[$], v.exp_raddr);
    if (v.exp_writes > 0 && wr_addr_q.size() > w0) begin
      check({tag, "_waddr"}, wr_addr_q[$], v.exp_waddr);
      check({tag, "_wdata"}, wr_data_q[$], v.exp_wdata);
    end
    if (v.exp_reads == 0 && v.exp_writes == 0)
      check({tag, "_no_bus_req"}, n_req - q0, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0, e0, r0, w0, f0, cyc, stab, lat;

    for (int i = 0; i < 6; i++) begin
      tbl[i].ent = '0;
      tbl[i].rd_value = 32'h0;
      tbl[i].exp_raddr = 32'h0;
      tbl[i].exp_waddr = 32'h0;
      tbl[i].exp_wdata = 32'h0;
    end
    // single WRITE then terminator
    tbl[0].ent[0] = mk(32'h100, 32'hAA, CMD_WRITE);
    tbl[0].exp_done = 1; tbl[0].exp_err = 0; tbl[0].exp_reads = 0; tbl[0].exp_writes = 1;
    tbl[0].exp_fetches = 2; tbl[0].exp_waddr = 32'h100; tbl[0].exp_wdata = 32'hAA;
    // RWM: (0x5A & 0x0F) | 0x30 = 0x3A
    tbl[1].ent[0] = mk(32'h200, 32'h0F, CMD_RWM);
    tbl[1].ent[1] = mk(32'h0, 32'h30, CMD_WRITE);
    tbl[1].rd_value = 32'h5A;
    tbl[1].exp_done = 1; tbl[1].exp_err = 0; tbl[1].exp_reads = 1; tbl[1].exp_writes = 1;
    tbl[1].exp_fetches = 3; tbl[1].exp_raddr = 32'h200; tbl[1].exp_waddr = 32'h200; tbl[1].exp_wdata = 32'h3A;
    // illegal type 2'b11 first
    tbl[2].ent[0] = mk(32'h180, 32'h1, 2'b11);
    tbl[2].exp_done = 0; tbl[2].exp_err = 1; tbl[2].exp_reads = 0; tbl[2].exp_writes = 0; tbl[2].exp_fetches = 1;
    // RWM followed by RWM
    tbl[3].ent[0] = mk(32'h240, 32'hF0, CMD_RWM);
    tbl[3].ent[1] = mk(32'h250, 32'h0F, CMD_RWM);
    tbl[3].rd_value = 32'h1234;
    tbl[3].exp_done = 0; tbl[3].exp_err = 1; tbl[3].exp_reads = 1; tbl[3].exp_writes = 0;
    tbl[3].exp_fetches = 2; tbl[3].exp_raddr = 32'h240;
    // illegal type 2'b10 first
    tbl[4].ent[0] = mk(32'h1C0, 32'h2, 2'b10);
    tbl[4].exp_done = 0; tbl[4].exp_err = 1; tbl[4].exp_reads = 0; tbl[4].exp_writes = 0; tbl[4].exp_fetches = 1;
    // two writes then terminator
    tbl[5].ent[0] = mk(32'h10, 32'h1, CMD_WRITE);
    tbl[5].ent[1] = mk(32'h14, 32'h2, CMD_WRITE);
    tbl[5].exp_done = 1; tbl[5].exp_err = 0; tbl[5].exp_reads = 0; tbl[5].exp_writes = 2;
    tbl[5].exp_fetches = 3; tbl[5].exp_waddr = 32'h14; tbl[5].exp_wdata = 32'h2;

    rst_n = 1'b0;
    start = 1'b0;
    rd_hold = 1'b0;
    rd_value = 32'h0;
    bus.mst_i_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case($sformatf("case%0d", i), tbl[i]);

    // Latency: start cycle counts as cycle 1, first mst_o_valid expected in cycle 4
    clear_mem();
    mem[0] = mk(32'h100, 32'hAA, CMD_WRITE);
    d0 = n_done; e0 = n_err;
    @(negedge clk);
    start = 1'b1;
    lat = 1;
    cyc = 0;
    while (!bus.mst_o_valid && cyc < 10) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      cyc++;
      if (lat == 2) check("lat_fetch_rd_en", 32'(cmd_rd_en), 32'd1);
    end
    check("latency", lat, 32'd4);
    wait_end("latency", 50, d0, e0);
    check("latency_done", n_done - d0, 32'd1);

    // Ready held low 5 cycles; a stray start while busy must be ignored
    clear_mem();
    mem[0] = mk(32'h300, 32'h55, CMD_WRITE);
    bus.mst_i_ready = 1'b0;
    d0 = n_done; e0 = n_err; w0 = wr_addr_q.size(); f0 = fetch_q.size();
    pulse_start();
    cyc = 0;
    while (!bus.mst_o_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    stab = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mst_o_valid && bus.mst_o_rd0_wr1 && bus.mst_o_addr == 32'h300 && bus.mst_o_wr_data == 32'h55)
        stab++;
      start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
`ifdef TIMEOUT_EN
    check("stall_stable_before_timeout", stab, 32'd3);
    check("stall_timeout_error", n_err - e0, 32'd1);
    check("stall_timeout_no_done", n_done - d0, 32'd0);
    check("stall_timeout_no_write", wr_addr_q.size() - w0, 32'd0);
    bus.mst_i_ready = 1'b1;
    repeat (2) @(negedge clk);
`else
    check("stall_stable", stab, 32'd5);
    bus.mst_i_ready = 1'b1;
    wait_end("stall", 50, d0, e0);
    check("stall_done", n_done - d0, 32'd1);
    check("stall_writes", wr_addr_q.size() - w0, 32'd1);
    check("stall_wdata", wr_data_q[$], 32'h55);
    check("stall_fetches", fetch_q.size() - f0, 32'd2);
`endif
    check("stall_idle_busy", 32'(busy), 32'd0);

    // Reset while waiting for read data, then restart from entry 0
    clear_mem();
    mem[0] = mk(32'h200, 32'h0F, CMD_RWM);
    mem[1] = mk(32'h0, 32'h30, CMD_WRITE);
    rd_hold = 1'b1;
    d0 = n_done; e0 = n_err; r0 = n_reads;
    pulse_start();
    cyc = 0;
    while (n_reads == r0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rdwait_busy", 32'(busy), 32'd1);
    check("rdwait_addr", bus.mst_o_addr, 32'h200);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("rdwait_reset");
    rst_n = 1'b1;
    rd_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rdwait_no_done", n_done - d0, 32'd0);
    check("rdwait_no_error", n_err - e0, 32'd0);
    run_case("restart", tbl[0]);

    // END_ADDR boundary: the entry at 0x4A0 is never fetched
    clear_mem();
    for (int k = 0; k < 296; k++) mem[k] = mk(32'h1000 + 32'(4 * k), 32'(k), CMD_WRITE);
    mem[296] = mk(32'h9000, 32'h1, CMD_RWM);
    d0 = n_done; e0 = n_err; w0 = wr_addr_q.size(); f0 = fetch_q.size();
    pulse_start();
    wait_end("end_write", 3000, d0, e0);
    check("end_write_done", n_done - d0, 32'd1);
    check("end_write_error", n_err - e0, 32'd0);
    check("end_write_writes", wr_addr_q.size() - w0, 32'd296);
    check("end_write_fetches", fetch_q.size() - f0, 32'd296);
    check("end_write_last_fetch", fetch_q[$], 32'h49C);
    check("end_write_last_waddr", wr_addr_q[$], 32'h149C);
    check("end_write_last_wdata", wr_data_q[$], 32'h127);

    // RWM in the last entry has no room for its partner
    mem[295] = mk(32'h2000, 32'hFF, CMD_RWM);
    mem[296] = mk(32'h0, 32'h1, CMD_WRITE);
    rd_value = 32'h77;
    d0 = n_done; e0 = n_err; r0 = n_reads; w0 = wr_addr_q.size(); f0 = fetch_q.size();
    pulse_start();
    wait_end("end_rwm", 3000, d0, e0);
    check("end_rwm_error", n_err - e0, 32'd1);
    check("end_rwm_done", n_done - d0, 32'd0);
    check("end_rwm_reads", n_reads - r0, 32'd1);
    check("end_rwm_writes", wr_addr_q.size() - w0, 32'd295);
    check("end_rwm_fetches", fetch_q.size() - f0, 32'd296);

    check("fetch_single_cycle", fetch_viol, 32'd0);
    check("bus_hold_until_ready", proto_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_executor.md
CMD_EXECUTOR -- requirements
Module: cmd_executor

Interface
REQ-001 SHALL have parameters, one per line:
- CMD_WIDTH, 64, width of one buffer entry.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, bus data width.
- END_ADDR, 32'h0000_04A0, first cmd_addr never fetched.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begin execution at cmd_addr 0.
- busy  out  1  high from start accept until DONE/ERR exit.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse on abort.
- cmd_rd_en  out  1  fetch request to the command buffer.
- cmd_addr  out  ADDR_WIDTH  entry address, step 4.
- cmd_rd_valid  in  1  cmd_out valid.
- cmd_out  in  CMD_WIDTH  fetched entry.
- mst_o_valid  out  1  bus request.
- mst_o_addr  out  ADDR_WIDTH  bus address.
- mst_o_wr_data  out  DATA_WIDTH  write data.
- mst_o_rd0_wr1  out  1  1 = write.
- mst_i_ready  in  1  request accepted.
- mst_i_rd_data  in  DATA_WIDTH  read data.
- mst_i_rd_valid  in  1  read data valid.

Function
REQ-003 Entry decode: type = cmd_out[1:0]; data = cmd_out[33:2]; bus address = {cmd_out[63:34], 2'b00}.
REQ-004 Types: 2'b00 WRITE; 2'b01 RWM; 2'b10 and 2'b11 illegal.
REQ-005 States: IDLE, FETCH, WAIT_CMD, WR_REQ, RD_REQ, RD_WAIT, FETCH2, WAIT_CMD2, DONE, ERR.
REQ-006 IDLE: start=1 goes to FETCH with cmd_addr=0 and busy=1; start is ignored outside IDLE.
REQ-007 FETCH/FETCH2: cmd_rd_en is high for exactly one cycle, then the block moves to WAIT_CMD/WAIT_CMD2.
REQ-008 WAIT_CMD: holds until cmd_rd_valid=1. An all-zero cmd_out goes to DONE. WRITE goes to WR_REQ. RWM goes to RD_REQ and latches address A and mask M. Illegal types go to ERR.
REQ-009 WR_REQ: mst_o_valid=1, mst_o_rd0_wr1=1, with address and data held stable until mst_i_ready=1. It then sets cmd_addr += 4 and goes to FETCH, or to DONE if the new cmd_addr == END_ADDR.
REQ-010 RD_REQ: mst_o_valid=1, mst_o_rd0_wr1=0 until mst_i_ready=1, then RD_WAIT; RD_WAIT latches R on mst_i_rd_valid=1 and goes to FETCH2 with cmd_addr += 4.
REQ-011 WAIT_CMD2: the partner entry SHALL be WRITE. Otherwise, or if the incremented cmd_addr == END_ADDR before fetch, the block goes to ERR. On WRITE with data D, it writes (R & M) | D to address A through WR_REQ.
REQ-012 DONE: done=1 for one cycle, busy=0, then IDLE. ERR: error=1 for one cycle, busy=0, then IDLE.
REQ-013 mst_o_valid SHALL never drop before mst_i_ready; at most one bus transaction is outstanding.
REQ-014 Minimum latency for one WRITE with mst_i_ready tied high: start to mst_o_valid is 4 cycles.

Reset
REQ-015 rst_n=0 at a clock edge forces IDLE and zeroes busy, done, error, cmd_rd_en, cmd_addr, mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1, and the latched A/M/R.
REQ-016 Reset in mid-operation abandons any bus transaction with no done or error pulse.

Configuration
REQ-017 With TIMEOUT_EN defined, a counter of parameter TIMEOUT_CYCLES (default 256) runs in WAIT_CMD, WAIT_CMD2, WR_REQ, RD_REQ and RD_WAIT, and clears on each state entry. Expiry goes to ERR.
REQ-018 Without TIMEOUT_EN, these states wait indefinitely, and neither the counter nor the parameter exists.

Structure
REQ-019 Package gp_engine_pkg SHALL hold the cmd type constants (WRITE, RWM), the state enum, and the cmd field bit positions; the command buffer SHALL import the same constants.
REQ-020 One sub-module, gp_watchdog (load/count/expire), instantiated only under TIMEOUT_EN.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Buffer {WRITE A=0x100 D=0xAA, zero}, ready=1 -> one write 0x100/0xAA, done pulse, cmd_addr reads 0,4.
- RWM A=0x200 M=0x0F then WRITE D=0x30, read returns 0x5A -> write 0x200 data 0x3A, done.
- Entry type 2'b11 at cmd_addr 0 -> error pulse, no bus request.
- RWM followed by RWM -> read issued, then error, no write.
- mst_i_ready held low 5 cycles -> address/data stable all 5 cycles; with TIMEOUT_EN and TIMEOUT_CYCLES=3 -> error instead.
- rst_n low during RD_WAIT -> all outputs 0 next cycle; a new start executes from cmd_addr 0.
